// File: rtl/divider_sequencer_if.sv
// Request/divider/response bundle for divider_sequencer.
// Ports: request stream (i_req_*/o_req_ready), divider begin/busy/result
// (o_begin, o_dividend, o_divisor, i_busy, i_quotient, i_remainder), response stream (o_rsp_*), FIFO occupancy.
interface divider_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // request stream
  logic             i_req_valid;
  logic             o_req_ready;
  logic [WIDTH-1:0] i_req_dividend;
  logic [WIDTH-1:0] i_req_divisor;
  // divider side
  logic             o_begin;
  logic [WIDTH-1:0] o_dividend;
  logic [WIDTH-1:0] o_divisor;
  logic             i_busy;
  logic [WIDTH-1:0] i_quotient;
  logic [WIDTH-1:0] i_remainder;
  // response stream
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [WIDTH-1:0] o_rsp_quotient;
  logic [WIDTH-1:0] o_rsp_remainder;
  logic             o_rsp_divZero;
  // status
  logic [CW-1:0]    o_fifoCount;

  // sequencer view
  modport slave (
    input  i_req_valid, i_req_dividend, i_req_divisor,
    input  i_busy, i_quotient, i_remainder, i_rsp_ready,
    output o_req_ready, o_begin, o_dividend, o_divisor,
    output o_rsp_valid, o_rsp_quotient, o_rsp_remainder, o_rsp_divZero, o_fifoCount
  );

  // environment view (producer, divider, consumer)
  modport master (
    output i_req_valid, i_req_dividend, i_req_divisor,
    output i_busy, i_quotient, i_remainder, i_rsp_ready,
    input  o_req_ready, o_begin, o_dividend, o_divisor,
    input  o_rsp_valid, o_rsp_quotient, o_rsp_remainder, o_rsp_divZero, o_fifoCount
  );
endinterface

// File: rtl/divider_sequencer.sv
// Front-end for a multi-cycle divider: buffers operand pairs in an in-order FIFO,
// issues one operation at a time on begin/busy, and returns quotient/remainder on a
// valid/ready response stream. Latency: accept at edge N, pop at N+1, o_begin in cycle N+2;
// response valid one cycle after busy drops. Backpressure: o_req_ready low when FIFO full;
// an unconsumed response stalls issue, never drops data. i_cg low freezes all state.
// Ports: i_clk, i_rst (async active-high), i_cg (clock enable), bus (divider_sequencer_if.slave).
// Optional macro DIVIDER_SEQUENCER_DIVZERO_EN: divisor==0 bypasses the divider and answers
// q=all ones, r=dividend, divZero=1.
module divider_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic            i_clk,
  input logic            i_rst,
  input logic            i_cg,
  divider_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
  } entry_t;

  state_e           state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q,  divisor_d;
  logic [WIDTH-1:0] rsp_quot_q, rsp_quot_d;
  logic [WIDTH-1:0] rsp_rem_q,  rsp_rem_d;
  logic             rsp_dz_q,   rsp_dz_d;
  logic             rsp_vld_q,  rsp_vld_d;

  logic   req_rdy;
  logic   push;
  logic   pop;
  entry_t head;

  // Ready depends only on the registered count, so it never combinationally
  // follows i_req_valid.
  assign req_rdy = (cnt_q != CW'(DEPTH));
  assign push    = bus.i_req_valid && req_rdy;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rsp_quot_d = rsp_quot_q;
    rsp_rem_d  = rsp_rem_q;
    rsp_dz_d   = rsp_dz_q;
    rsp_vld_d  = rsp_vld_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if ((cnt_q != '0) && !bus.i_busy) begin
          pop        = 1'b1;
          dividend_d = head.dividend;
          divisor_d  = head.divisor;
`ifdef DIVIDER_SEQUENCER_DIVZERO_EN
          if (head.divisor == '0) begin
            // Answer locally; the divider never sees this operation.
            rsp_quot_d = '1;
            rsp_rem_d  = head.dividend;
            rsp_dz_d   = 1'b1;
            rsp_vld_d  = 1'b1;
            state_d    = RESP;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Busy is already high in the first WAIT cycle, so the first low
        // sample marks a valid result.
        if (!bus.i_busy) begin
          rsp_quot_d = bus.i_quotient;
          rsp_rem_d  = bus.i_remainder;
          rsp_dz_d   = 1'b0;
          rsp_vld_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{dividend: bus.i_req_dividend, divisor: bus.i_req_divisor};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_q      <= '{default: '0};
      dividend_q <= '0;
      divisor_q  <= '0;
      rsp_quot_q <= '0;
      rsp_rem_q  <= '0;
      rsp_dz_q   <= 1'b0;
      rsp_vld_q  <= 1'b0;
    end else if (i_cg) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rsp_quot_q <= rsp_quot_d;
      rsp_rem_q  <= rsp_rem_d;
      rsp_dz_q   <= rsp_dz_d;
      rsp_vld_q  <= rsp_vld_d;
    end
  end

  // Gating the pulse with i_cg keeps a frozen ISSUE state from starting the divider.
  assign bus.o_begin         = (state_q == ISSUE) && i_cg;
  assign bus.o_req_ready     = req_rdy;
  assign bus.o_dividend      = dividend_q;
  assign bus.o_divisor       = divisor_q;
  assign bus.o_rsp_valid     = rsp_vld_q;
  assign bus.o_rsp_quotient  = rsp_quot_q;
  assign bus.o_rsp_remainder = rsp_rem_q;
  assign bus.o_rsp_divZero   = rsp_dz_q;
  assign bus.o_fifoCount     = cnt_q;
endmodule

// File: tb/tb_divider_sequencer.sv
// Directed-vector bench for divider_sequencer with a behavioural divider,
// a scoreboard queue of expected responses and a decoupled response monitor.
module tb_divider_sequencer;
  localparam int W = 8;
  localparam int D = 4;

  logic clk;
  logic rst;
  logic cg;

  divider_sequencer_if #(.WIDTH(W), .DEPTH(D)) bus();

  divider_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_cg (cg),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   begin_cnt = 0;
  int   div_lat = 5;
  int   div_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Behavioural divider: busy from the edge after o_begin for div_lat cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.i_busy      <= 1'b0;
      bus.i_quotient  <= '0;
      bus.i_remainder <= '0;
      div_left        <= 0;
    end else if (bus.o_begin) begin
      bus.i_busy <= 1'b1;
      div_left   <= div_lat;
      if (bus.o_divisor == '0) begin
        bus.i_quotient  <= '1;
        bus.i_remainder <= bus.o_dividend;
      end else begin
        bus.i_quotient  <= bus.o_dividend / bus.o_divisor;
        bus.i_remainder <= bus.o_dividend % bus.o_divisor;
      end
    end else if (bus.i_busy) begin
      if (div_left <= 1) bus.i_busy <= 1'b0;
      else div_left <= div_left - 1;
    end
  end

  // Monitor: counts begin pulses and checks every response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_begin) begin_cnt++;
    if (!rst && cg && bus.o_rsp_valid && bus.i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got q=%0d r=%0d expected none", bus.o_rsp_quotient, bus.o_rsp_remainder);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_quotient", bus.o_rsp_quotient, e.q);
        chk("rsp_remainder", bus.o_rsp_remainder, e.r);
        chk("rsp_divZero", bus.o_rsp_divZero, e.dz);
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    logic ok;
    ok = 1'b0;
    exp_q.push_back('{q: eq, r: er, dz: edz});
    bus.i_req_valid    = 1'b1;
    bus.i_req_dividend = a;
    bus.i_req_divisor  = b;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      ok = bus.o_req_ready;
      @(posedge clk);
      if (ok) break;
    end
    #1;
    bus.i_req_valid = 1'b0;
    if (!ok) fail_now("send");
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.o_fifoCount == 0 && !bus.i_busy && !bus.o_rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_begin(input int b0);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (begin_cnt > b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("wait_begin");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   b0;
    int   b1;
    logic stable;
    logic fell;

    rst = 1'b1;
    cg  = 1'b1;
    bus.i_req_valid    = 1'b0;
    bus.i_req_dividend = '0;
    bus.i_req_divisor  = '0;
    bus.i_rsp_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_fifoCount", bus.o_fifoCount, 0);
    chk("rst_req_ready", bus.o_req_ready, 1);
    chk("rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("rst_begin", bus.o_begin, 0);
    chk("rst_dividend", bus.o_dividend, 0);
    chk("rst_divisor", bus.o_divisor, 0);
    chk("rst_rsp_q", bus.o_rsp_quotient, 0);
    chk("rst_rsp_r", bus.o_rsp_remainder, 0);
    chk("rst_divZero", bus.o_rsp_divZero, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single request, minimum latency
    b0 = begin_cnt;
    send(100, 7, 14, 2, 1'b0);
    @(posedge clk);
    #1;
    chk("t1_begin_cycle", bus.o_begin, 1);
    chk("t1_dividend", bus.o_dividend, 100);
    chk("t1_divisor", bus.o_divisor, 7);
    chk("t1_count_popped", bus.o_fifoCount, 0);
    fell = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      if (!bus.i_busy) begin
        fell = 1'b1;
        break;
      end
    end
    if (!fell) fail_now("t1_busy_fall");
    chk("t1_rsp_not_early", bus.o_rsp_valid, 0);
    @(posedge clk);
    #1;
    chk("t1_rsp_valid", bus.o_rsp_valid, 1);
    wait_idle();
    chk("t1_begin_once", begin_cnt - b0, 1);
    chk("t1_count_end", bus.o_fifoCount, 0);

    // fill FIFO while the divider is busy
    div_lat = 40;
    b0 = begin_cnt;
    send(100, 7, 14, 2, 1'b0);
    wait_begin(b0);
    send(255, 16, 15, 15, 1'b0);
    send(9, 3, 3, 0, 1'b0);
    send(0, 5, 0, 0, 1'b0);
    send(200, 201, 0, 200, 1'b0);
    chk("t2_count_full", bus.o_fifoCount, 4);
    chk("t2_ready_full", bus.o_req_ready, 0);
    bus.i_req_valid    = 1'b1;
    bus.i_req_dividend = 1;
    bus.i_req_divisor  = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("t2_full_hold", bus.o_fifoCount, 4);
    bus.i_req_valid = 1'b0;
    wait_idle();
    chk("t2_begin_count", begin_cnt - b0, 5);
    div_lat = 5;

    // response back-pressure
    bus.i_rsp_ready = 1'b0;
    b0 = begin_cnt;
    send(50, 6, 8, 2, 1'b0);
    send(81, 9, 9, 0, 1'b0);
    fell = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.o_rsp_valid) begin
        fell = 1'b1;
        break;
      end
    end
    if (!fell) fail_now("t3_rsp_valid");
    b1 = begin_cnt;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(bus.o_rsp_valid && bus.o_rsp_quotient == 8 && bus.o_rsp_remainder == 2)) stable = 1'b0;
    end
    chk("t3_held_stable", stable, 1);
    chk("t3_one_begin", b1 - b0, 1);
    chk("t3_no_new_begin", begin_cnt - b1, 0);
    chk("t3_queued", bus.o_fifoCount, 1);
    @(posedge clk);
    #1;
    bus.i_rsp_ready = 1'b1;
    wait_idle();
    chk("t3_next_issued", begin_cnt - b0, 2);

    // divide by zero
    b0 = begin_cnt;
`ifdef DIVIDER_SEQUENCER_DIVZERO_EN
    send(200, 0, 255, 200, 1'b1);
    wait_idle();
    chk("t4_no_begin", begin_cnt - b0, 0);
`else
    send(200, 0, 255, 200, 1'b0);
    wait_idle();
    chk("t4_begin", begin_cnt - b0, 1);
`endif

    // reset in WAIT with two entries queued
    div_lat = 30;
    b0 = begin_cnt;
    send(20, 4, 5, 0, 1'b0);
    wait_begin(b0);
    send(30, 5, 6, 0, 1'b0);
    send(40, 8, 5, 0, 1'b0);
    chk("t5_queued", bus.o_fifoCount, 2);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rsp_valid", bus.o_rsp_valid, 0);
    chk("t5_count", bus.o_fifoCount, 0);
    chk("t5_ready", bus.o_req_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    b0 = begin_cnt;
    repeat (60) @(posedge clk);
    #1;
    chk("t5_no_reissue", begin_cnt - b0, 0);
    chk("t5_count_after", bus.o_fifoCount, 0);
    div_lat = 5;

    // clock gate during ISSUE
    b0 = begin_cnt;
    send(7, 2, 3, 1, 1'b0);
    @(posedge clk);
    #1;
    chk("t6_issue", bus.o_begin, 1);
    cg = 1'b0;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_begin || bus.o_fifoCount != 0 || bus.o_dividend != 7 || bus.o_rsp_valid) stable = 1'b0;
    end
    chk("t6_frozen", stable, 1);
    @(posedge clk);
    #1;
    cg = 1'b1;
    #1;
    chk("t6_resume", bus.o_begin, 1);
    wait_idle();
    chk("t6_begin_once", begin_cnt - b0, 1);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/divider_sequencer.md
Name: divider_sequencer

Overview:
- Request front-end that sits directly upstream of the multi-cycle dividerFsm.
- Accepts operand pairs on a valid/ready stream and buffers them in a small in-order FIFO.
- Issues one operation at a time on the divider's begin/busy interface, captures quotient and remainder, and presents them on a valid/ready response stream.
- Lets producers stream division requests without tracking divider busy state themselves.

Parameters:
- WIDTH, 8: width of dividend, divisor, quotient and remainder; must match the attached divider.
- DEPTH, 4: request FIFO entries; power of 2, at least 2.

Ports:
- i_clk  input  1  single clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_cg  input  1  clock gate; all state holds while low.
- i_req_valid  input  1  request offered.
- o_req_ready  output  1  FIFO not full; registered.
- i_req_dividend  input  WIDTH  request dividend.
- i_req_divisor  input  WIDTH  request divisor.
- o_begin  output  1  one-cycle start pulse to the divider.
- o_dividend  output  WIDTH  registered operand to the divider.
- o_divisor  output  WIDTH  registered operand to the divider.
- i_busy  input  1  divider busy.
- i_quotient  input  WIDTH  divider quotient.
- i_remainder  input  WIDTH  divider remainder.
- o_rsp_valid  output  1  response held.
- i_rsp_ready  input  1  consumer accepts response.
- o_rsp_quotient  output  WIDTH  registered result.
- o_rsp_remainder  output  WIDTH  registered result.
- o_rsp_divZero  output  1  response came from divide-by-zero bypass.
- o_fifoCount  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: asynchronous, active-high.
  - FIFO is emptied; o_fifoCount=0, o_req_ready=1.
  - FSM goes to IDLE; o_begin=0, o_rsp_valid=0.
  - o_dividend, o_divisor, o_rsp_quotient, o_rsp_remainder and o_rsp_divZero all reset to 0.
- Clock gate: state, FIFO and output registers update only when i_cg=1; o_begin = (state==ISSUE) && i_cg.
- Request push: on (i_req_valid && o_req_ready) at an enabled edge.
  - o_req_ready = (count != DEPTH), computed from the registered count.
  - A push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- Divider contract:
  - i_busy is high from the cycle after o_begin until the result is ready.
  - i_quotient and i_remainder are valid in the first cycle i_busy is low after that.
- FSM states:
  - IDLE: if FIFO non-empty and !i_busy, pop the head into o_dividend/o_divisor and go to ISSUE. Otherwise stay.
  - ISSUE: o_begin=1 for exactly one cycle; go to WAIT.
  - WAIT: while i_busy, stay. When !i_busy, capture i_quotient/i_remainder into the response registers, set o_rsp_valid, clear o_rsp_divZero, go to RESP.
  - RESP: hold o_rsp_valid and the data stable until i_rsp_ready; on handshake clear o_rsp_valid and go to IDLE.
- Minimum latency with an empty FIFO and idle divider:
  - Request accepted at edge N, popped at edge N+1, o_begin high in cycle N+2.
  - o_rsp_valid high one cycle after the divider drops busy.
- Ordering and concurrency:
  - Responses are strictly in request order.
  - At most one operation is in flight; no new o_begin is issued while a response is unconsumed.
- FIFO fill during activity: requests keep being accepted during WAIT/RESP until full.
- Boundary cases:
  - A full FIFO stalls the producer only (ready=0).
  - A response back-pressured indefinitely stalls issue but never drops data.
  - Reset during WAIT or RESP aborts the operation; no response is produced, and the divider shares i_rst.

Optional Feature:
- Macro: DIVIDER_SEQUENCER_DIVZERO_EN.
- When defined: IDLE popping an entry with divisor==0 skips ISSUE/WAIT, issues no o_begin, and goes directly to RESP with:
  - o_rsp_quotient = all ones;
  - o_rsp_remainder = the dividend;
  - o_rsp_divZero = 1.
- When undefined: divisor==0 is forwarded to the divider like any other operand and o_rsp_divZero is tied 0.

Test Plan:
- Single request 100/7, rsp_ready=1 -> o_begin exactly once; response q=14, r=2, divZero=0; o_fifoCount back to 0.
- Four back-to-back requests 255/16, 9/3, 0/5, 200/201 with DEPTH=4 while the divider is busy -> o_req_ready=0 once count=4; responses in order (15,15), (3,0), (0,0), (0,200).
- Response back-pressure: 50/6 with i_rsp_ready=0 for 20 cycles -> o_rsp_valid and q=8, r=2 held stable, no further o_begin; release -> next queued request issues.
- Macro defined: 200/0 -> no o_begin; response q=255, r=200, divZero=1. Macro undefined: o_begin asserted and divZero=0.
- Reset asserted mid-WAIT with 2 entries queued -> o_rsp_valid=0, o_fifoCount=0, o_req_ready=1 immediately (asynchronous), no response after release.
- i_cg low for 10 cycles during ISSUE -> o_begin low, state and count frozen; resumes with exactly one o_begin pulse when i_cg=1.
